// File: rtl/issue_scoreboard_mp_if.sv
// Issue-scoreboard bus: IQ head fields, write-back and completion inputs,
// and the issue/stall/launch outputs.
// The master side drives the head and write-back signals; the slave side is the scoreboard.
interface issue_scoreboard_mp_if #(
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 5,
  parameter int NUM_PIPES = 4
) ();
  logic                 flush;
  logic                 head_valid;
  logic [NUM_PIPES-1:0] head_pipe;
  logic                 head_reg_write;
  logic [REG_WIDTH-1:0] head_rd;
  logic [REG_WIDTH-1:0] head_rs1;
  logic [REG_WIDTH-1:0] head_rs2;
  logic                 wb_en;
  logic [REG_WIDTH-1:0] wb_rd;
  logic [NUM_PIPES-1:0] var_done;
  logic                 issue;
  logic [NUM_PIPES-1:0] issue_pipe;
  logic [NUM_REGS-1:0]  busy_regs;
  logic                 stall_sb;
  logic                 stall_wb;
  logic                 stall_var;

  modport master (
    output flush, head_valid, head_pipe, head_reg_write, head_rd, head_rs1, head_rs2,
           wb_en, wb_rd, var_done,
    input  issue, issue_pipe, busy_regs, stall_sb, stall_wb, stall_var
  );

  modport slave (
    input  flush, head_valid, head_pipe, head_reg_write, head_rd, head_rs1, head_rs2,
           wb_en, wb_rd, var_done,
    output issue, issue_pipe, busy_regs, stall_sb, stall_wb, stall_var
  );
endinterface

// File: rtl/issue_scoreboard_mp.sv
// Issue-gating scoreboard at the IQ head. Tracks pending destination GPRs,
// reserves the single write-back port for fixed-latency pipes, caps outstanding
// ops on variable-latency pipes, and remembers the most recent marked rd values
// so a flush can release them.
module issue_scoreboard_mp #(
  parameter int                     NUM_REGS        = 32,
  parameter int                     REG_WIDTH       = 5,
  parameter int                     NUM_PIPES       = 4,
  parameter int                     MAX_LATENCY     = 8,
  parameter logic [8*NUM_PIPES-1:0] PIPE_LATENCY    = {8'd3, 8'd2, 8'd2, 8'd1},
  parameter logic [NUM_PIPES-1:0]   VAR_PIPE_MASK   = 4'b1000,
  parameter int                     MAX_OUTSTANDING = 1,
  parameter int                     FLUSH_DEPTH     = 2
) (
  input logic                  clk,
  input logic                  rst,
  issue_scoreboard_mp_if.slave sb
);

  localparam int CNT_W = 4;

  // Checks that every fixed pipe latency fits the reservation vector.
  function automatic bit latencies_ok();
    bit ok;
    ok = 1'b1;
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (!VAR_PIPE_MASK[p]) begin
        if ((PIPE_LATENCY[p*8 +: 8] == 8'd0) || (int'(PIPE_LATENCY[p*8 +: 8]) > MAX_LATENCY)) begin
          ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

  if (!latencies_ok()) begin : g_bad_latency
    $error("issue_scoreboard_mp: fixed pipe latency must be 1..MAX_LATENCY");
  end
  if (REG_WIDTH != $clog2(NUM_REGS)) begin : g_bad_reg_width
    $error("issue_scoreboard_mp: REG_WIDTH must equal clog2(NUM_REGS)");
  end
  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 15)) begin : g_bad_outstanding
    $error("issue_scoreboard_mp: MAX_OUTSTANDING must be 1..15");
  end
  if (FLUSH_DEPTH < 1) begin : g_bad_flush_depth
    $error("issue_scoreboard_mp: FLUSH_DEPTH must be at least 1");
  end

  logic [NUM_REGS-1:0]    busy_r;
  logic [NUM_REGS-1:0]    busy_next_s;
  logic [NUM_REGS-1:0]    set_s;
  logic [NUM_REGS-1:0]    clr_s;
  logic [MAX_LATENCY-1:0] resv_r;
  logic [MAX_LATENCY-1:0] resv_next_s;
  logic [MAX_LATENCY-1:0] resv_claim_s;
  logic [CNT_W-1:0]       cnt_r      [NUM_PIPES];
  logic [CNT_W-1:0]       cnt_next_s [NUM_PIPES];
  logic [NUM_PIPES-1:0]   cnt_inc_s;
  logic [NUM_PIPES-1:0]   cnt_dec_s;
  logic [FLUSH_DEPTH-1:0] hist_vld_r;
  logic [REG_WIDTH-1:0]   hist_rd_r  [FLUSH_DEPTH];
  logic [NUM_PIPES-1:0]   issue_pipe_r;
  logic [7:0]             head_lat_s;
  logic                   head_nop_s;
  logic                   head_fixed_s;
  logic                   stall_sb_s;
  logic                   stall_wb_s;
  logic                   stall_var_s;
  logic                   issue_s;
  logic                   mark_s;

  // Decode the head pipe: NOP/fixed class, fixed latency, and the outstanding cap.
  always_comb begin
    head_nop_s   = (sb.head_pipe == {NUM_PIPES{1'b0}});
    head_fixed_s = |(sb.head_pipe & ~VAR_PIPE_MASK);
    head_lat_s   = 8'd0;
    stall_var_s  = 1'b0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      head_lat_s  = head_lat_s |
                    ({8{sb.head_pipe[p] & ~VAR_PIPE_MASK[p]}} & PIPE_LATENCY[p*8 +: 8]);
      stall_var_s = stall_var_s |
                    (sb.head_pipe[p] & VAR_PIPE_MASK[p] & (cnt_r[p] == CNT_W'(MAX_OUTSTANDING)));
    end
  end

  // Write-back port conflict: the slot the head would write in is already claimed.
  always_comb begin
    stall_wb_s = 1'b0;
    for (int i = 0; i < MAX_LATENCY; i++) begin
      stall_wb_s = stall_wb_s | (head_fixed_s & resv_r[i] & (head_lat_s == 8'(i + 1)));
    end
  end

  // Source/destination hazard against pending registers; x0 is never busy.
  always_comb begin
    stall_sb_s = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      stall_sb_s = stall_sb_s | (busy_r[r] & ((sb.head_rd  == REG_WIDTH'(r)) |
                                              (sb.head_rs1 == REG_WIDTH'(r)) |
                                              (sb.head_rs2 == REG_WIDTH'(r))));
    end
  end

  assign issue_s = sb.head_valid & ~sb.flush & ~stall_sb_s & ~stall_wb_s & ~stall_var_s;
  assign mark_s  = issue_s & sb.head_reg_write & ~head_nop_s &
                   (sb.head_rd != {REG_WIDTH{1'b0}});

  // Busy-register set/clear vectors; a flush also releases every history entry.
  always_comb begin
    set_s = {NUM_REGS{1'b0}};
    clr_s = {NUM_REGS{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      set_s[r] = mark_s & (sb.head_rd == REG_WIDTH'(r));
      clr_s[r] = sb.wb_en & (sb.wb_rd == REG_WIDTH'(r));
      for (int d = 0; d < FLUSH_DEPTH; d++) begin
        clr_s[r] = clr_s[r] | (sb.flush & hist_vld_r[d] & (hist_rd_r[d] == REG_WIDTH'(r)));
      end
    end
    busy_next_s = (busy_r & ~clr_s) | set_s;
  end

  // Reservation vector: age by one slot; a fixed issue with L>=2 claims slot L-2.
  always_comb begin
    resv_claim_s = {MAX_LATENCY{1'b0}};
    for (int i = 0; i < MAX_LATENCY - 1; i++) begin
      resv_claim_s[i] = issue_s & head_fixed_s & (head_lat_s == 8'(i + 2));
    end
    if (sb.flush) begin
      resv_next_s = {MAX_LATENCY{1'b0}};
    end else begin
      resv_next_s = (resv_r >> 1) | resv_claim_s;
    end
  end

  assign cnt_inc_s = {NUM_PIPES{issue_s}} & sb.head_pipe & VAR_PIPE_MASK;
  assign cnt_dec_s = sb.var_done & VAR_PIPE_MASK;

  // Outstanding counters: issue and completion in one cycle cancel; never below zero.
  always_comb begin
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (sb.flush) begin
        cnt_next_s[p] = {CNT_W{1'b0}};
      end else if (cnt_inc_s[p] && cnt_dec_s[p]) begin
        cnt_next_s[p] = cnt_r[p];
      end else if (cnt_inc_s[p]) begin
        cnt_next_s[p] = cnt_r[p] + 4'd1;
      end else if (cnt_dec_s[p] && (cnt_r[p] != {CNT_W{1'b0}})) begin
        cnt_next_s[p] = cnt_r[p] - 4'd1;
      end else begin
        cnt_next_s[p] = cnt_r[p];
      end
    end
  end

  // Scoreboard, reservation, counter and launch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= {NUM_REGS{1'b0}};
      resv_r       <= {MAX_LATENCY{1'b0}};
      issue_pipe_r <= {NUM_PIPES{1'b0}};
      for (int p = 0; p < NUM_PIPES; p++) begin
        cnt_r[p] <= {CNT_W{1'b0}};
      end
    end else begin
      busy_r       <= busy_next_s;
      resv_r       <= resv_next_s;
      issue_pipe_r <= sb.head_pipe & {NUM_PIPES{issue_s}};
      for (int p = 0; p < NUM_PIPES; p++) begin
        cnt_r[p] <= cnt_next_s[p];
      end
    end
  end

  // Flush-recovery history: newest marked rd in entry 0, older entries shift up.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_r <= {FLUSH_DEPTH{1'b0}};
      for (int d = 0; d < FLUSH_DEPTH; d++) begin
        hist_rd_r[d] <= {REG_WIDTH{1'b0}};
      end
    end else if (sb.flush) begin
      hist_vld_r <= {FLUSH_DEPTH{1'b0}};
    end else if (mark_s) begin
      for (int d = FLUSH_DEPTH - 1; d > 0; d--) begin
        hist_vld_r[d] <= hist_vld_r[d-1];
        hist_rd_r[d]  <= hist_rd_r[d-1];
      end
      hist_vld_r[0] <= 1'b1;
      hist_rd_r[0]  <= sb.head_rd;
    end else begin
      hist_vld_r <= hist_vld_r;
    end
  end

  assign sb.issue      = issue_s;
  assign sb.issue_pipe = issue_pipe_r;
  assign sb.busy_regs  = busy_r;
  assign sb.stall_sb   = stall_sb_s;
  assign sb.stall_wb   = stall_wb_s;
  assign sb.stall_var  = stall_var_s;

endmodule

// File: tb/tb_issue_scoreboard_mp.sv
// Self-checking bench for issue_scoreboard_mp: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (busy set, claimed write-back cycles, counters, rd history).
module tb_issue_scoreboard_mp;

  logic clk;
  logic rst;

  issue_scoreboard_mp_if #(.NUM_REGS(32), .REG_WIDTH(5), .NUM_PIPES(4)) sb_if ();

  issue_scoreboard_mp dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int lat_tab [4] = '{1, 2, 2, 3};
  bit var_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam int MAX_OUT = 1;
  localparam int FDEPTH  = 2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        model_ok = 1'b0;
  int        now = 0;
  bit [31:0] mbusy;
  int        claims[$];
  int        mcnt [4];
  int        hist[$];
  bit [3:0]  mpipe;

  function automatic bit claimed(input int cyc);
    foreach (claims[i]) if (claims[i] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reg_busy(input int r);
    return (r != 0) && mbusy[r];
  endfunction

  int  pidx, elat;
  bit  e_nop, e_fixed, e_var, e_sb, e_wb, e_vs, e_iss, e_mark, dn;

  always @(negedge clk) begin : compare
    pidx = -1;
    for (int p = 0; p < 4; p++) if (sb_if.head_pipe[p]) pidx = p;
    e_nop   = (pidx < 0);
    elat    = e_nop ? 0 : lat_tab[pidx];
    e_fixed = !e_nop && !var_tab[pidx];
    e_var   = !e_nop && var_tab[pidx];
    e_sb    = reg_busy(int'(sb_if.head_rd)) || reg_busy(int'(sb_if.head_rs1)) ||
              reg_busy(int'(sb_if.head_rs2));
    e_wb    = e_fixed && claimed(now + elat);
    e_vs    = e_var && (mcnt[pidx] == MAX_OUT);
    e_iss   = sb_if.head_valid && !sb_if.flush && !e_sb && !e_wb && !e_vs;
    e_mark  = e_iss && sb_if.head_reg_write && !e_nop && (sb_if.head_rd != 5'd0);

    if (model_ok) begin
      chk("issue",      64'(sb_if.issue),      64'(e_iss));
      chk("stall_sb",   64'(sb_if.stall_sb),   64'(e_sb));
      chk("stall_wb",   64'(sb_if.stall_wb),   64'(e_wb));
      chk("stall_var",  64'(sb_if.stall_var),  64'(e_vs));
      chk("busy_regs",  64'(sb_if.busy_regs),  64'(mbusy));
      chk("issue_pipe", 64'(sb_if.issue_pipe), 64'(mpipe));
    end

    if (rst) begin
      model_ok = 1'b1;
      mbusy = 32'd0; claims = {}; hist = {}; mpipe = 4'd0;
      for (int p = 0; p < 4; p++) mcnt[p] = 0;
    end else begin
      mpipe = e_iss ? sb_if.head_pipe : 4'd0;
      if (sb_if.wb_en) mbusy[sb_if.wb_rd] = 1'b0;
      if (sb_if.flush) begin
        foreach (hist[i]) mbusy[hist[i]] = 1'b0;
        hist = {}; claims = {};
        for (int p = 0; p < 4; p++) mcnt[p] = 0;
      end else begin
        if (e_mark) begin
          mbusy[sb_if.head_rd] = 1'b1;
          hist.push_front(int'(sb_if.head_rd));
          if (hist.size() > FDEPTH) void'(hist.pop_back());
        end
        if (e_iss && e_fixed && elat >= 2) claims.push_back(now + elat);
        for (int p = 0; p < 4; p++) begin
          if (var_tab[p]) begin
            dn = sb_if.var_done[p];
            if (e_iss && pidx == p && dn) mcnt[p] = mcnt[p];
            else if (e_iss && pidx == p)  mcnt[p] = mcnt[p] + 1;
            else if (dn && mcnt[p] > 0)   mcnt[p] = mcnt[p] - 1;
          end
        end
      end
      mbusy[0] = 1'b0;
    end
    now++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    sb_if.flush = 1'b0; sb_if.head_valid = 1'b0; sb_if.head_pipe = 4'd0;
    sb_if.head_reg_write = 1'b0; sb_if.head_rd = 5'd0; sb_if.head_rs1 = 5'd0;
    sb_if.head_rs2 = 5'd0; sb_if.wb_en = 1'b0; sb_if.wb_rd = 5'd0; sb_if.var_done = 4'd0;
  endtask

  task automatic head(input bit v, input bit [3:0] pipe, input bit w,
                      input int rd, input int rs1, input int rs2);
    sb_if.head_valid = v; sb_if.head_pipe = pipe; sb_if.head_reg_write = w;
    sb_if.head_rd = 5'(rd); sb_if.head_rs1 = 5'(rs1); sb_if.head_rs2 = 5'(rs2);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    do_reset();

    // RAW on x5 through a latency-1 pipe; no write-back bypass
    head(1, 4'b0001, 1, 5, 0, 0); settle();
    chk("raw_t0_issue", 64'(sb_if.issue), 64'd1);
    tick(); head(1, 4'b0010, 1, 6, 5, 0); settle();
    chk("raw_t1_issue", 64'(sb_if.issue), 64'd0);
    chk("raw_t1_stall_sb", 64'(sb_if.stall_sb), 64'd1);
    chk("raw_t1_launch", 64'(sb_if.issue_pipe), 64'h1);
    chk("raw_t1_busy", 64'(sb_if.busy_regs), 64'h20);
    tick(); settle();
    chk("raw_t2_issue", 64'(sb_if.issue), 64'd0);
    tick(); sb_if.wb_en = 1'b1; sb_if.wb_rd = 5'd5; settle();
    chk("raw_t3_no_bypass", 64'(sb_if.issue), 64'd0);
    tick(); sb_if.wb_en = 1'b0; settle();
    chk("raw_t4_issue", 64'(sb_if.issue), 64'd1);
    tick();
    do_reset();

    // Write-back port collision: L=2 then L=1 land in the same cycle
    head(1, 4'b0010, 0, 0, 0, 0); settle();
    chk("wb_t0_issue", 64'(sb_if.issue), 64'd1);
    tick(); head(1, 4'b0001, 0, 0, 0, 0); settle();
    chk("wb_t1_stall_wb", 64'(sb_if.stall_wb), 64'd1);
    chk("wb_t1_issue", 64'(sb_if.issue), 64'd0);
    tick(); settle();
    chk("wb_t2_issue", 64'(sb_if.issue), 64'd1);
    tick();
    do_reset();

    // Variable pipe cap, and done on an idle counter must not underflow
    head(1, 4'b1000, 0, 0, 0, 0); settle();
    chk("var_t0_issue", 64'(sb_if.issue), 64'd1);
    tick(); settle();
    chk("var_t1_stall", 64'(sb_if.stall_var), 64'd1);
    tick(); sb_if.var_done = 4'b1000; settle();
    chk("var_t2_issue", 64'(sb_if.issue), 64'd0);
    tick(); sb_if.var_done = 4'b0000; settle();
    chk("var_t3_issue", 64'(sb_if.issue), 64'd1);
    tick(); head(0, 4'b0000, 0, 0, 0, 0); sb_if.var_done = 4'b1000;
    tick(); tick(); sb_if.var_done = 4'b0000; head(1, 4'b1000, 0, 0, 0, 0); settle();
    chk("var_t6_issue", 64'(sb_if.issue), 64'd1);
    tick(); settle();
    chk("var_t7_stall", 64'(sb_if.stall_var), 64'd1);
    tick();
    do_reset();

    // Flush releases x7 and x9, zeroes the DIV counter
    head(1, 4'b1000, 1, 7, 0, 0);
    tick(); head(1, 4'b0010, 1, 9, 0, 0);
    tick(); head(1, 4'b0001, 1, 3, 0, 0); sb_if.flush = 1'b1; settle();
    chk("fl_t2_issue", 64'(sb_if.issue), 64'd0);
    chk("fl_t2_busy", 64'(sb_if.busy_regs), 64'h280);
    tick(); sb_if.flush = 1'b0; head(1, 4'b1000, 0, 0, 0, 0); settle();
    chk("fl_t3_busy", 64'(sb_if.busy_regs), 64'h0);
    chk("fl_t3_issue", 64'(sb_if.issue), 64'd1);
    tick();
    do_reset();

    // rd=x0 never marks; NOPs issue every cycle
    head(1, 4'b0001, 1, 0, 0, 0); settle();
    chk("x0_issue", 64'(sb_if.issue), 64'd1);
    tick(); head(1, 4'b0000, 1, 4, 0, 0); settle();
    chk("nop1_issue", 64'(sb_if.issue), 64'd1);
    tick(); settle();
    chk("nop2_issue", 64'(sb_if.issue), 64'd1);
    chk("nop2_busy", 64'(sb_if.busy_regs), 64'h0);
    tick();

    // Mid-stream reset with x5 and x9 pending
    head(1, 4'b0001, 1, 5, 0, 0);
    tick(); head(1, 4'b0001, 1, 9, 0, 0);
    tick(); head(1, 4'b0001, 1, 3, 0, 0); settle();
    chk("rst_pre_busy", 64'(sb_if.busy_regs), 64'h220);
    rst = 1'b1;
    tick(); rst = 1'b0; idle(); settle();
    chk("rst_busy", 64'(sb_if.busy_regs), 64'h0);
    chk("rst_launch", 64'(sb_if.issue_pipe), 64'h0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      sb_if.flush = ($urandom_range(0, 24) == 0);
      sb_if.head_valid = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 6) == 0) sb_if.head_pipe = 4'd0;
      else sb_if.head_pipe = 4'(1 << $urandom_range(0, 3));
      sb_if.head_reg_write = ($urandom_range(0, 3) != 0);
      sb_if.head_rd  = 5'($urandom_range(0, 11));
      sb_if.head_rs1 = 5'($urandom_range(0, 11));
      sb_if.head_rs2 = 5'($urandom_range(0, 11));
      sb_if.wb_en    = ($urandom_range(0, 9) < 6);
      sb_if.wb_rd    = 5'($urandom_range(0, 11));
      sb_if.var_done = 4'($urandom_range(0, 15)) & {($urandom_range(0, 2) == 0), 3'b111};
      tick();
    end
    rst = 1'b0;
    idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
